// File: rtl/cv32e41s_csr_integrity_monitor.sv
// Round-robin scanner of hardened-CSR rd_error flags with a mismatch filter, error logging and alert handshake.
// Latency: FILTER cycles from the IDLE sample cycle of a failing CSR to alert_req_o=1.
// Backpressure: scanning stalls while an alert is pending; resumes after the 4-phase ack completes.
module cv32e41s_csr_integrity_monitor #(
  parameter int unsigned NUM_CSR = 8,
  parameter int unsigned FILTER  = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned IDX_W   = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [NUM_CSR-1:0] csr_rd_error_i,
  input  logic               alert_ack_i,
  input  logic               clear_i,
  output logic [IDX_W-1:0]   scan_idx_o,
  output logic               alert_req_o,
  output logic [IDX_W-1:0]   err_idx_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic               err_sticky_o,
  output logic [CNT_W-1:0]   transient_cnt_o
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CSR - 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, ALERT, ACKWAIT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, cand_q;
  logic [FW-1:0]    filt_q;
  logic [CNT_W-1:0] cnt_q, tr_q, cnt_base;
  logic [IDX_W-1:0] err_idx_q;
  logic             sticky_q;

  logic             cur_err, cand_err, enter_alert;
  logic [IDX_W-1:0] ptr_inc, cand_inc;

  assign cur_err     = csr_rd_error_i[ptr_q];
  assign cand_err    = csr_rd_error_i[cand_q];
  assign ptr_inc     = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
  assign cand_inc    = (cand_q == LAST_IDX) ? '0 : cand_q + IDX_W'(1);
  assign enter_alert = (state_d == ALERT) && (state_q != ALERT);
  // A clear in the same IDLE cycle as an alert entry zeroes the base before the increment lands.
  assign cnt_base    = ((state_q == IDLE) && clear_i) ? '0 : cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_i && cur_err) state_d = (FILTER == 1) ? ALERT : CONFIRM;
      end
      CONFIRM: begin
        if (!enable_i)               state_d = IDLE;
        else if (!cand_err)          state_d = IDLE;
        else if (filt_q == FILT_LAST) state_d = ALERT;
      end
      ALERT: begin
        if (alert_ack_i) state_d = ACKWAIT;
      end
      ACKWAIT: begin
        if (!alert_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: request is high for the whole registered ALERT state
  always_comb begin
    alert_req_o = (state_q == ALERT);
  end

  // Scan pointer, filter, counters and error log
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      cand_q    <= '0;
      filt_q    <= '0;
      cnt_q     <= '0;
      tr_q      <= '0;
      err_idx_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            tr_q     <= '0;
          end
          if (enable_i) begin
            if (cur_err) begin
              cand_q <= ptr_q;
              filt_q <= FW'(1);
            end else begin
              ptr_q <= ptr_inc;
            end
          end
        end
        CONFIRM: begin
          if (enable_i) begin
            if (cand_err) begin
              filt_q <= filt_q + FW'(1);
            end else begin
              if (tr_q != {CNT_W{1'b1}}) tr_q <= tr_q + CNT_W'(1);
              filt_q <= '0;
              ptr_q  <= ptr_inc;
            end
          end
        end
        ACKWAIT: begin
          if (!alert_ack_i) begin
            ptr_q  <= cand_inc;
            filt_q <= '0;
          end
        end
        default: ;
      endcase
      if (enter_alert) begin
        err_idx_q <= (state_q == IDLE) ? ptr_q : cand_q;
        cnt_q     <= (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + CNT_W'(1);
        sticky_q  <= 1'b1;
      end
    end
  end

  assign scan_idx_o      = ptr_q;
  assign err_idx_o       = err_idx_q;
  assign err_cnt_o       = cnt_q;
  assign err_sticky_o    = sticky_q;
  assign transient_cnt_o = tr_q;

endmodule

// File: tb/tb_cv32e41s_csr_integrity_monitor.sv
// Bench for the CSR integrity monitor: per-cycle scoreboard against a behavioural model plus directed checks.
// Latency: expected outputs are queued before each clock edge and compared 1 time unit after it.
// Backpressure: alert handshake driven explicitly by the stimulus sequences.
module tb_cv32e41s_csr_integrity_monitor;
  localparam int NUM_CSR = 8;
  localparam int FILTER  = 2;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 3;

  localparam int S_IDLE = 0, S_CONF = 1, S_ALERT = 2, S_ACKW = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [NUM_CSR-1:0] err = '0;
  logic               ack = 1'b0;
  logic               clr = 1'b0;
  logic [IDX_W-1:0]   scan_idx;
  logic               alert_req;
  logic [IDX_W-1:0]   err_idx;
  logic [CNT_W-1:0]   err_cnt;
  logic               err_sticky;
  logic [CNT_W-1:0]   transient_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // Behavioural model state
  int m_st = S_IDLE, m_ptr = 0, m_cand = 0, m_filt = 0, m_idx = 0, m_cnt = 0, m_tr = 0;
  bit m_sticky = 1'b0;

  always #5 clk = ~clk;

  cv32e41s_csr_integrity_monitor #(
    .NUM_CSR(NUM_CSR), .FILTER(FILTER), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .csr_rd_error_i (err),
    .alert_ack_i    (ack),
    .clear_i        (clr),
    .scan_idx_o     (scan_idx),
    .alert_req_o    (alert_req),
    .err_idx_o      (err_idx),
    .err_cnt_o      (err_cnt),
    .err_sticky_o   (err_sticky),
    .transient_cnt_o(transient_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap_inc(input int p);
    return (p + 1) % NUM_CSR;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit go_alert = 1'b0;
    if (rst) begin
      m_st = S_IDLE; m_ptr = 0; m_cand = 0; m_filt = 0;
      m_idx = 0; m_cnt = 0; m_tr = 0; m_sticky = 1'b0;
      return;
    end
    case (m_st)
      S_IDLE: begin
        if (clr) begin m_cnt = 0; m_sticky = 1'b0; m_tr = 0; end
        if (enable) begin
          if (err[m_ptr]) begin
            m_cand = m_ptr; m_filt = 1;
            if (FILTER == 1) go_alert = 1'b1; else m_st = S_CONF;
          end else begin
            m_ptr = wrap_inc(m_ptr);
          end
        end
      end
      S_CONF: begin
        if (!enable) m_st = S_IDLE;
        else if (err[m_cand]) begin
          m_filt++;
          if (m_filt == FILTER) go_alert = 1'b1;
        end else begin
          if (m_tr < (1 << CNT_W) - 1) m_tr++;
          m_filt = 0; m_ptr = wrap_inc(m_ptr); m_st = S_IDLE;
        end
      end
      S_ALERT: if (ack) m_st = S_ACKW;
      default: if (!ack) begin m_ptr = wrap_inc(m_cand); m_st = S_IDLE; end
    endcase
    if (go_alert) begin
      m_st = S_ALERT; m_idx = m_cand; m_sticky = 1'b1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  function automatic logic [31:0] model_out();
    return {8'h0, IDX_W'(m_ptr), (m_st == S_ALERT), IDX_W'(m_idx), CNT_W'(m_cnt), m_sticky, CNT_W'(m_tr)};
  endfunction

  // One clock: queue the model's prediction, then compare the DUT after the edge
  task automatic tick();
    logic [31:0] exp;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("cyc", {8'h0, scan_idx, alert_req, err_idx, err_cnt, err_sticky, transient_cnt}, exp);
  endtask

  task automatic wait_scan(input int idx, input int budget);
    int n = 0;
    while (scan_idx != IDX_W'(idx) && n < budget) begin tick(); n++; end
    if (scan_idx != IDX_W'(idx)) check("scan_timeout", 32'(scan_idx), 32'(idx));
  endtask

  task automatic wait_req(input int budget, output int cycles);
    cycles = 0;
    while (!alert_req && cycles < budget) begin tick(); cycles++; end
    if (!alert_req) check("req_timeout", 32'(alert_req), 32'd1);
  endtask

  task automatic handshake();
    ack = 1'b1; tick();
    check("req_drop", 32'(alert_req), 32'd0);
    ack = 1'b0; tick();
  endtask

  initial begin
    int lat;
    tick(); tick();
    check("rst_scan", 32'(scan_idx), 32'd0);
    check("rst_req", 32'(alert_req), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);

    // Clean scan: 0..7 then wrap to 0
    rst = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("scan_seq", 32'(scan_idx), 32'(i % NUM_CSR));
      check("scan_noalert", 32'(alert_req), 32'd0);
    end
    tick(); tick();
    rst = 1'b1; tick();
    check("rst_mid", 32'(scan_idx), 32'd0);
    rst = 1'b0;

    // Persistent error on CSR 5
    err = 8'b0010_0000;
    wait_scan(5, 20);
    wait_req(10, lat);
    check("alert_lat", 32'(lat), 32'd2);
    check("err_idx", 32'(err_idx), 32'd5);
    check("err_cnt1", 32'(err_cnt), 32'd1);
    check("sticky1", 32'(err_sticky), 32'd1);
    tick(); tick();
    check("req_held", 32'(alert_req), 32'd1);
    err = '0;
    handshake();
    check("resume6", 32'(scan_idx), 32'd6);

    // One-cycle glitch on CSR 3
    wait_scan(3, 20);
    err = 8'b0000_1000; tick();
    err = '0; tick();
    check("glitch_tr", 32'(transient_cnt), 32'd1);
    check("glitch_scan", 32'(scan_idx), 32'd4);
    tick(); tick();
    check("glitch_noreq", 32'(alert_req), 32'd0);
    check("glitch_cnt", 32'(err_cnt), 32'd1);

    // Clear during ALERT is ignored
    err = 8'b0000_0100;
    wait_req(20, lat);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_alert_cnt", 32'(err_cnt), 32'd2);
    check("clr_alert_sticky", 32'(err_sticky), 32'd1);
    err = '0;
    handshake();

    // Clear in IDLE
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_tr", 32'(transient_cnt), 32'd0);

    // Enable dropped during CONFIRM
    wait_scan(1, 20);
    err = 8'b0000_0010; tick();
    enable = 1'b0; tick();
    check("endrop_scan", 32'(scan_idx), 32'd1);
    check("endrop_tr", 32'(transient_cnt), 32'd0);
    check("endrop_cnt", 32'(err_cnt), 32'd0);
    err = '0; ack = 1'b1; tick();
    check("ackidle_scan", 32'(scan_idx), 32'd1);
    enable = 1'b1; tick();
    check("ackidle_adv", 32'(scan_idx), 32'd2);
    check("ackidle_req", 32'(alert_req), 32'd0);
    ack = 1'b0; tick();

    // Saturation of the confirmed-error counter
    err = '1;
    for (int k = 0; k < 256; k++) begin
      wait_req(20, lat);
      handshake();
    end
    check("sat255", 32'(err_cnt), 32'd255);
    wait_req(20, lat);
    check("sat_hold", 32'(err_cnt), 32'd255);
    handshake();
    err = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
